pc_ctrl: RTL
============

// Module: pc_ctrl
// PURPOSE
//  Parametrised program-counter controller for the RV32/RV64 fetch stage. Holds IP,
//  advances by 4, and freezes on control-flow opcodes until the execute stage resolves
//  them, then redirects (PC-relative branch/JAL, absolute JALR) or falls through.
//  Adds hazard hold, misaligned-target trap, resolve handshake and a redirect counter.
// PARAMETERS
//  XLEN       32            address/data width (32 or 64)
//  RESET_VEC  'h0           IP value loaded on reset
//  TRAP_VEC   'h100         IP loaded when a taken target is misaligned
//  CNT_W      32            width of redirect_cnt performance counter
// PORTS
//  CLK           in   1      clock, all state updates on posedge
//  RESET         in   1      synchronous, active-high
//  opcode        in   7      opcode of instruction currently at IP
//  op_valid      in   1      opcode is valid this cycle
//  hold          in   1      pipeline hazard stall; freeze IP
//  resolve_valid in   1      execute stage presents outcome of pending control op
//  taken         in   1      branch/jump taken (qualified by resolve_valid)
//  is_abs        in   1      1: use target_abs (JALR), 0: branch_pc + target_rel
//  target_rel    in   XLEN   signed PC-relative offset
//  target_abs    in   XLEN   absolute target (rs1+imm)
//  ip            out  XLEN   current fetch address
//  pc_def        out  XLEN   ip + 4 (combinational, link value)
//  fetch_valid   out  1      ip is a valid fetch this cycle
//  misalign      out  1      one-cycle pulse: taken target had bits[1:0] != 0
//  redirect_cnt  out  CNT_W  count of taken redirects since reset
// BEHAVIOUR
//  Reset (RESET=1 at posedge): ip=RESET_VEC, state=RUN, branch_pc=0, misalign=0,
//   redirect_cnt=0. RESET overrides every other input, any state, including WAIT.
//  States: RUN, WAIT.
//  RUN:
//   - hold=1 -> ip unchanged, stay RUN (hold beats control-op detection).
//   - op_valid & opcode in {1101111 JAL, 1100111 JALR, 1100011 BRANCH} -> ip unchanged,
//     branch_pc<=ip, next WAIT.
//   - otherwise ip<=ip+4 (wraps modulo 2^XLEN).
//  WAIT: ip frozen; hold and opcode ignored; waits indefinitely for resolve_valid.
//   - resolve_valid & !taken -> ip<=branch_pc+4, next RUN.
//   - resolve_valid & taken  -> tgt = is_abs ? (target_abs & ~1) : branch_pc+target_rel
//     (XLEN-bit wrap, no overflow flag). If tgt[1:0]!=0: ip<=TRAP_VEC, misalign=1 next
//     cycle only; else ip<=tgt. redirect_cnt++ in both cases (saturates at all-ones).
//     next RUN.
//  fetch_valid = (state==RUN) & !hold; comb. 0 throughout WAIT.
//  Latency: redirect visible on ip the cycle after resolve_valid; first fetch at
//   RESET_VEC one cycle after RESET deasserts.
//  resolve_valid in RUN is ignored (no pending op); taken/is_abs ignored without it.
//  Back-to-back: control op at redirected target re-enters WAIT from RUN normally.
// STRUCTURE
//  pc_pkg: opcode constants OP_JAL/OP_JALR/OP_BRANCH, typedef enum {RUN,WAIT} pc_state_t.
//  Sub-module pc_target_calc (comb): branch_pc, is_abs, target_rel, target_abs ->
//   tgt, misaligned. Rest (FSM, IP/branch_pc regs, counter) in pc_ctrl.
// TESTING
//  1 Reset then 4 cycles no ops -> ip 0,4,8,C,10; fetch_valid=1; redirect_cnt=0.
//  2 At ip=0x10 opcode=1100011; resolve_valid,taken=0 after 3 cycles -> ip holds 0x10,
//    fetch_valid=0 for 3 cycles, then ip=0x14, redirect_cnt=0.
//  3 At ip=0x20 BRANCH, taken, target_rel=-8 -> ip=0x18, redirect_cnt=1;
//    JALR at 0x18, target_abs=0x41 -> ip=0x40 (bit0 cleared, no misalign).
//  4 JAL at 0x40, taken, target_rel=0x6 -> ip=TRAP_VEC (0x100), misalign pulse 1 cycle.
//  5 hold=1 for 2 cycles at ip=0x8 with op_valid JAL -> ip stays 0x8, no WAIT;
//    release -> enters WAIT. RESET asserted in WAIT -> ip=RESET_VEC, state RUN, cnt=0.
//  6 XLEN=64, ip near 2^64-4, no ops -> ip wraps to 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants and types for the fetch-stage program-counter controller.
package pc_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } pc_state_t;

  function automatic logic is_ctrl_op(input logic [6:0] op);
    return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Taken-target computation: PC-relative or absolute (bit0 cleared), plus alignment flag.
module pc_target_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] branch_pc,
  input  logic            is_abs,
  input  logic [XLEN-1:0] target_rel,
  input  logic [XLEN-1:0] target_abs,
  output logic [XLEN-1:0] tgt,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] CLR_B0 = ~XLEN'(1);

  // Relative add wraps modulo 2^XLEN; no overflow is reported.
  assign tgt        = is_abs ? (target_abs & CLR_B0) : (branch_pc + target_rel);
  assign misaligned = |tgt[1:0];

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage PC controller: sequential advance, freeze on control ops until resolved.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
  parameter int              CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [6:0]       opcode,
  input  logic             op_valid,
  input  logic             hold,
  input  logic             resolve_valid,
  input  logic             taken,
  input  logic             is_abs,
  input  logic [XLEN-1:0]  target_rel,
  input  logic [XLEN-1:0]  target_abs,
  output logic [XLEN-1:0]  ip,
  output logic [XLEN-1:0]  pc_def,
  output logic             fetch_valid,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [XLEN-1:0] INC = XLEN'(4);

  pc_state_t       state;
  logic [XLEN-1:0] branch_pc;
  logic [XLEN-1:0] tgt;
  logic            tgt_mis;

  pc_target_calc #(.XLEN(XLEN)) u_tgt (
    .branch_pc  (branch_pc),
    .is_abs     (is_abs),
    .target_rel (target_rel),
    .target_abs (target_abs),
    .tgt        (tgt),
    .misaligned (tgt_mis)
  );

  assign pc_def      = ip + INC;
  assign fetch_valid = (state == RUN) && !hold;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= RUN;
      ip           <= RESET_VEC;
      branch_pc    <= '0;
      misalign     <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      misalign <= 1'b0;
      case (state)
        RUN: begin
          // A stall wins over control-op detection; the op is seen again once released.
          if (!hold) begin
            if (op_valid && is_ctrl_op(opcode)) begin
              branch_pc <= ip;
              state     <= WAIT;
            end else begin
              ip <= ip + INC;
            end
          end
        end
        WAIT: begin
          if (resolve_valid) begin
            state <= RUN;
            if (!taken) begin
              ip <= branch_pc + INC;
            end else begin
              if (tgt_mis) begin
                ip       <= TRAP_VEC;
                misalign <= 1'b1;
              end else begin
                ip <= tgt;
              end
              if (!(&redirect_cnt))
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
